ws2801_driver: RTL and testbench

WS2801_DRIVER -- requirements
Module: ws2801_driver

---
 rtl/ws2801_driver.sv | 151 +++++++++++++++
 tb/tb_ws2801_driver.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2801_driver.sv
// Streams LEDS 24-bit pixels MSB-first to a WS2801 chain over a two-wire clock/data link,
// then holds the clock low long enough for the chain to latch the frame.
module ws2801_driver #(
    parameter int LEDS         = 5,
    parameter int HALF_PERIOD  = 2,
    parameter int LATCH_CYCLES = 25500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] pixelData,
    input  logic        pixelValid,
    output logic        pixelReady,
    output logic        ledClk,
    output logic        ledData,
    output logic        busy,
    output logic        done
);

    localparam int PIX_W = $clog2(LEDS + 1);
    localparam int HP_W  = $clog2(HALF_PERIOD + 1);
    localparam int LAT_W = $clog2(LATCH_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } state_t;

    state_t             state_q, state_d;
    logic [23:0]        shift_q, shift_d;
    logic [4:0]         bit_q, bit_d;
    logic [PIX_W-1:0]   pix_q, pix_d;
    logic [HP_W-1:0]    hp_q, hp_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic               ledclk_q, ledclk_d;
    logic               leddata_q, leddata_d;
    logic               done_q, done_d;
    logic               hp_last;

    assign hp_last = (hp_q == HP_W'(HALF_PERIOD - 1));

    always_comb begin
        // NOTE: every next-state value defaults to its current value first, so no path infers a latch.
        state_d   = state_q;
        shift_d   = shift_q;
        bit_d     = bit_q;
        pix_d     = pix_q;
        hp_d      = hp_q;
        lat_d     = lat_q;
        leddata_d = leddata_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    pix_d   = '0;
                end
            end
            LOAD: begin
                if (pixelValid) begin
                    shift_d   = pixelData;
                    bit_d     = 5'd23;
                    hp_d      = '0;
                    leddata_d = pixelData[23];
                    state_d   = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (hp_last) begin
                    hp_d    = '0;
                    state_d = SHIFT_HI;
                end else begin
                    hp_d = hp_q + 1'b1;
                end
            end
            SHIFT_HI: begin
                if (!hp_last) begin
                    hp_d = hp_q + 1'b1;
                end else begin
                    hp_d = '0;
                    if (bit_q != 5'd0) begin
                        // Data only moves here, as the clock falls, giving a full half-period of setup and hold.
                        shift_d   = shift_q << 1;
                        bit_d     = bit_q - 5'd1;
                        leddata_d = shift_d[23];
                        state_d   = SHIFT_LO;
                    end else begin
                        pix_d = pix_q + 1'b1;
                        if (pix_d == PIX_W'(LEDS)) begin
                            lat_d     = '0;
                            leddata_d = 1'b0;
                            state_d   = LATCH;
                        end else begin
                            state_d = LOAD;
                        end
                    end
                end
            end
            LATCH: begin
                // done is raised while still in LATCH, so a start in the same cycle finds the FSM busy.
                done_d = (lat_q == LAT_W'(LATCH_CYCLES - 1));
                if (lat_q == LAT_W'(LATCH_CYCLES)) begin
                    lat_d   = '0;
                    state_d = IDLE;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // NOTE: ledClk is decoded from the next state and registered, so the pin is glitch-free and aligned with the FSM.
        ledclk_d = (state_d == SHIFT_HI);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only; reset is synchronous and clears every flop.
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_q     <= '0;
            pix_q     <= '0;
            hp_q      <= '0;
            lat_q     <= '0;
            ledclk_q  <= 1'b0;
            leddata_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            pix_q     <= pix_d;
            hp_q      <= hp_d;
            lat_q     <= lat_d;
            ledclk_q  <= ledclk_d;
            leddata_q <= leddata_d;
            done_q    <= done_d;
        end
    end

    assign pixelReady = (state_q == LOAD);
    assign busy       = (state_q != IDLE);
    assign ledClk     = ledclk_q;
    assign ledData    = leddata_q;
    assign done       = done_q;

endmodule

// File: tb/tb_ws2801_driver.sv
// Scoreboard bench for ws2801_driver: expected bits are queued at pixel accept and popped on each
// ledClk rise; a two-LED WS2801 chain model checks what the LEDs finally latch.
module tb_ws2801_driver;

    localparam int LEDS = 2;
    localparam int HP   = 2;
    localparam int LAT  = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [23:0] pixelData = '0;
    logic        pixelValid = 1'b0;
    logic        pixelReady, ledClk, ledData, busy, done;

    ws2801_driver #(.LEDS(LEDS), .HALF_PERIOD(HP), .LATCH_CYCLES(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pixelData  (pixelData),
        .pixelValid (pixelValid),
        .pixelReady (pixelReady),
        .ledClk     (ledClk),
        .ledData    (ledData),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;

    bit          exp_q[$];
    int          rise_cnt = 0;
    int          accept_cyc = 0;
    int          last_fall_cyc = 0;
    bit          have_fall = 1'b0;
    int          done_count = 0;
    logic        prev_clk = 1'b0;
    logic        rise_data = 1'b0;
    logic [23:0] rx [2];
    logic [23:0] led [2];
    int          rx_bits = 0;
    int          low_cnt = 0;

    // Scoreboard, timing monitor and two-LED WS2801 chain model, all sampled mid-cycle.
    always @(negedge clk) begin
        if (ledClk === 1'b1 && prev_clk === 1'b0) begin
            if (rise_cnt % 24 == 0) begin
                checks++;
                if (cyc - accept_cyc != HP + 1) begin
                    errors++;
                    $display("FAIL first_rise_delay: got %0d cycles, want %0d", cyc - accept_cyc, HP + 1);
                end
            end
            if (rise_cnt == 0 && have_fall) begin
                checks++;
                if (cyc - last_fall_cyc < LAT) begin
                    errors++;
                    $display("FAIL inter_frame_low: got %0d cycles, want >= %0d", cyc - last_fall_cyc, LAT);
                end
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rise: got a ledClk rise, want none (rise %0d)", rise_cnt);
            end else begin
                bit e;
                e = exp_q.pop_front();
                if (ledData !== e) begin
                    errors++;
                    $display("FAIL bit_%0d: got %b, want %b", rise_cnt, ledData, e);
                end
            end
            if (rx_bits < 48) rx[rx_bits / 24] = {rx[rx_bits / 24][22:0], ledData};
            rx_bits++;
            rise_data = ledData;
            rise_cnt++;
        end else if (ledClk === 1'b1) begin
            checks++;
            if (ledData !== rise_data) begin
                errors++;
                $display("FAIL data_hold: got %b while ledClk high, want %b", ledData, rise_data);
            end
        end
        if (ledClk === 1'b0 && prev_clk === 1'b1) begin
            last_fall_cyc = cyc;
            have_fall = 1'b1;
        end
        if (ledClk === 1'b0) begin
            low_cnt++;
            if (low_cnt == LAT && rx_bits > 0) begin
                led[0]  = rx[0];
                led[1]  = rx[1];
                rx_bits = 0;
            end
        end else begin
            low_cnt = 0;
        end
        if (done === 1'b1) done_count++;
        prev_clk = ledClk;
    end

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; pixelValid = 1'b1; pixelData = 24'h123456;
        repeat (3) @(negedge clk);
        checks++; if (ledClk !== 1'b0)     begin errors++; $display("FAIL reset_ledClk: got %b, want 0", ledClk); end
        checks++; if (ledData !== 1'b0)    begin errors++; $display("FAIL reset_ledData: got %b, want 0", ledData); end
        checks++; if (pixelReady !== 1'b0) begin errors++; $display("FAIL reset_pixelReady: got %b, want 0", pixelReady); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b, want 0", busy); end
        checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done: got %b, want 0", done); end
        rst = 1'b0; start = 1'b0; pixelValid = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_priority: got busy=%b, want 0", busy); end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (pixelReady !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        checks++;
        if (pixelReady !== 1'b1) begin errors++; $display("FAIL %s_ready_timeout: got pixelReady=%b, want 1", tag, pixelReady); end
    endtask

    task automatic run_frame(input logic [23:0] p0, input logic [23:0] p1, input int stall, input bit pulse);
        logic [23:0] px [2];
        int          acc [2];
        int          n;
        int          base_done;
        px[0] = p0; px[1] = p1;
        rise_cnt  = 0;
        base_done = done_count;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %b, want 1", busy); end
        for (int i = 0; i < 2; i++) begin
            wait_ready("pixel");
            if (i == 1 && stall > 0) begin
                for (int s = 0; s < stall; s++) begin
                    checks++;
                    if (ledClk !== 1'b0 || pixelReady !== 1'b1) begin
                        errors++;
                        $display("FAIL stall_%0d: got ledClk=%b pixelReady=%b, want 0 1", s, ledClk, pixelReady);
                    end
                    @(negedge clk);
                end
            end
            pixelData  = px[i];
            pixelValid = 1'b1;
            accept_cyc = cyc;
            acc[i]     = cyc;
            for (int b = 23; b >= 0; b--) exp_q.push_back(px[i][b]);
            @(negedge clk);
            pixelValid = 1'b0;
            if (pulse && i == 1) begin
                n = 0;
                while (ledClk !== 1'b1 && n < 100) begin @(negedge clk); n++; end
                start = 1'b1;
                @(negedge clk) start = 1'b0;
            end
        end
        if (stall == 0) begin
            checks++;
            if (acc[1] - acc[0] != 48 * HP + 1) begin
                errors++;
                $display("FAIL pixel_period: got %0d cycles, want %0d", acc[1] - acc[0], 48 * HP + 1);
            end
        end
        if (pulse) begin
            n = 0;
            while (!(rise_cnt == 48 && ledClk === 1'b0) && n < 500) begin @(negedge clk); n++; end
            start = 1'b1;
            @(negedge clk) start = 1'b0;
        end
        n = 0;
        while (done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout: got done=%b, want 1", done);
        end else begin
            checks++;
            if (cyc - last_fall_cyc != LAT) begin
                errors++;
                $display("FAIL done_delay: got %0d cycles after last fall, want %0d", cyc - last_fall_cyc, LAT);
            end
        end
        if (pulse) start = 1'b1;
        @(negedge clk) start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_done: got %b, want 0", busy); end
        checks++; if (rise_cnt != 48) begin errors++; $display("FAIL rise_count: got %0d, want 48", rise_cnt); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bits_left: got %0d, want 0", exp_q.size()); end
        repeat (LAT + 10) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_frame: got busy=%b, want 0", busy); end
        checks++;
        if (done_count - base_done != 1) begin
            errors++;
            $display("FAIL done_pulses: got %0d, want 1", done_count - base_done);
        end
        checks++; if (led[0] !== p0) begin errors++; $display("FAIL led0: got %h, want %h", led[0], p0); end
        checks++; if (led[1] !== p1) begin errors++; $display("FAIL led1: got %h, want %h", led[1], p1); end
    endtask

    task automatic test_frame();
        run_frame(24'hFFFFFF, 24'hF0F0F0, 0, 1'b0);
        run_frame(24'hA5C30F, 24'h000001, 0, 1'b0);
    endtask

    task automatic test_stall();
        run_frame(24'hA5C30F, 24'h3C5A96, 50, 1'b0);
    endtask

    task automatic test_reset_mid();
        int n;
        int base_done;
        rise_cnt  = 0;
        base_done = done_count;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_ready("abort");
        pixelData  = 24'hA5C30F;
        pixelValid = 1'b1;
        accept_cyc = cyc;
        for (int b = 23; b >= 0; b--) exp_q.push_back(pixelData[b]);
        @(negedge clk);
        pixelValid = 1'b0;
        n = 0;
        while (rise_cnt < 11 && n < 500) begin @(negedge clk); n++; end
        checks++; if (rise_cnt != 11) begin errors++; $display("FAIL abort_reach_bit10: got %0d rises, want 11", rise_cnt); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (ledClk !== 1'b0)     begin errors++; $display("FAIL abort_ledClk: got %b, want 0", ledClk); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL abort_busy: got %b, want 0", busy); end
        checks++; if (pixelReady !== 1'b0) begin errors++; $display("FAIL abort_pixelReady: got %b, want 0", pixelReady); end
        exp_q.delete();
        repeat (150) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_stays_idle: got busy=%b, want 0", busy); end
        checks++;
        if (done_count != base_done) begin
            errors++;
            $display("FAIL abort_no_done: got %0d pulses, want 0", done_count - base_done);
        end
        run_frame(24'hA5C30F, 24'h0F1E2D, 0, 1'b0);
    endtask

    task automatic test_start_ignored();
        run_frame(24'h123456, 24'h89ABCD, 0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_frame();
        test_stall();
        test_reset_mid();
        test_start_ignored();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
